// File: rtl/simt_scheduler_if.sv
// rtl/simt_scheduler_if.sv - control bundle between a SIMT core and its scheduler
interface simt_scheduler_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
);
  localparam int T = THREADS_PER_BLOCK;
  localparam int A = PROGRAM_MEM_ADDR_BITS;

  logic                 start;
  logic [$clog2(T):0]   thread_count;
  logic [2:0]           fetcher_state;
  logic                 decoded_mem_read_enable;
  logic                 decoded_mem_write_enable;
  logic                 decoded_ret;
  logic [2*T-1:0]       lsu_state;
  logic [A*T-1:0]       next_pc;

  logic [2:0]           core_state;
  logic [A-1:0]         current_pc;
  logic [T-1:0]         active_mask;
  logic                 done;

  modport master (
    output start, thread_count, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, active_mask, done
  );

  modport slave (
    input  start, thread_count, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, active_mask, done
  );
endinterface

// File: rtl/simt_scheduler.sv
// rtl/simt_scheduler.sv - SIMT block scheduler with min-PC reconvergence
// Per-lane PC divergence tracking is enabled by SIMT_SCHEDULER_DIVERGENCE_EN.
module simt_scheduler #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  simt_scheduler_if.slave  bus
);
  localparam int T  = THREADS_PER_BLOCK;
  localparam int A  = PROGRAM_MEM_ADDR_BITS;
  localparam int CW = $clog2(T) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  current_pc_q, current_pc_d;
  logic [T-1:0]  active_mask_q, active_mask_d;
  logic [T-1:0]  enabled_q, enabled_d;
  logic [T-1:0]  retired_q, retired_d;

  logic [CW-1:0] n_lanes;
  logic [T-1:0]  start_lanes;
  logic          lsu_busy;

  assign n_lanes = (bus.thread_count > CW'(T)) ? CW'(T) : bus.thread_count;

  always_comb begin
    start_lanes = '0;
    for (int i = 0; i < T; i++) begin
      start_lanes[i] = (CW'(i) < n_lanes);
    end
  end

  // Only lanes issuing the current instruction can hold the block in WAIT.
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (active_mask_q[i] &&
          (bus.lsu_state[2*i +: 2] == 2'b01 || bus.lsu_state[2*i +: 2] == 2'b10)) begin
        lsu_busy = 1'b1;
      end
    end
  end

`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
  logic [A-1:0] pc_q   [T];
  logic [A-1:0] pc_d   [T];
  logic [A-1:0] upd_pc [T];
  logic [T-1:0] upd_retired;
  logic [A-1:0] min_pc;
  logic [T-1:0] min_mask;
  logic         min_found;

  always_comb begin
    upd_retired = retired_q | (bus.decoded_ret ? active_mask_q : '0);
    for (int i = 0; i < T; i++) begin
      upd_pc[i] = (active_mask_q[i] && !bus.decoded_ret) ? bus.next_pc[A*i +: A] : pc_q[i];
    end
  end

  // Reselect: the lowest pending PC issues next; parked lanes rejoin on equality.
  always_comb begin
    min_pc    = '0;
    min_found = 1'b0;
    min_mask  = '0;
    for (int i = 0; i < T; i++) begin
      if (enabled_q[i] && !upd_retired[i] && (!min_found || upd_pc[i] < min_pc)) begin
        min_pc    = upd_pc[i];
        min_found = 1'b1;
      end
    end
    for (int i = 0; i < T; i++) begin
      min_mask[i] = enabled_q[i] && !upd_retired[i] && (upd_pc[i] == min_pc);
    end
  end
`else
  logic [A-1:0] last_pc;

  always_comb begin
    last_pc = current_pc_q;
    for (int i = 0; i < T; i++) begin
      if (active_mask_q[i]) begin
        last_pc = bus.next_pc[A*i +: A];
      end
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    current_pc_d  = current_pc_q;
    active_mask_d = active_mask_q;
    enabled_d     = enabled_q;
    retired_d     = retired_q;
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
    pc_d          = pc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          enabled_d     = start_lanes;
          retired_d     = ~start_lanes;
          active_mask_d = start_lanes;
          current_pc_d  = '0;
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
          for (int i = 0; i < T; i++) begin
            pc_d[i] = '0;
          end
`endif
          state_d = (n_lanes == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:   if (bus.fetcher_state == 3'b010) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!lsu_busy) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
        retired_d = upd_retired;
        pc_d      = upd_pc;
        if (min_found) begin
          current_pc_d  = min_pc;
          active_mask_d = min_mask;
          state_d       = S_FETCH;
        end else begin
          active_mask_d = '0;
          state_d       = S_DONE;
        end
`else
        if (bus.decoded_ret) begin
          retired_d     = '1;
          active_mask_d = '0;
          state_d       = S_DONE;
        end else begin
          current_pc_d  = last_pc;
          active_mask_d = enabled_q & ~retired_q;
          state_d       = S_FETCH;
        end
`endif
      end
      S_DONE:  if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      current_pc_q  <= '0;
      active_mask_q <= '0;
      enabled_q     <= '0;
      retired_q     <= '1;
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
      for (int i = 0; i < T; i++) begin
        pc_q[i] <= '0;
      end
`endif
    end else begin
      state_q       <= state_d;
      current_pc_q  <= current_pc_d;
      active_mask_q <= active_mask_d;
      enabled_q     <= enabled_d;
      retired_q     <= retired_d;
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
      pc_q          <= pc_d;
`endif
    end
  end

  assign bus.core_state  = state_q;
  assign bus.current_pc  = current_pc_q;
  assign bus.active_mask = active_mask_q;
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_simt_scheduler.sv
// tb/tb_simt_scheduler.sv - self-checking bench for simt_scheduler
module tb_simt_scheduler;
  localparam int T  = 4;
  localparam int A  = 8;
  localparam int CW = $clog2(T) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  simt_scheduler_if #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) bus ();

  simt_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  int           m_st;
  logic [A-1:0] m_cur;
  logic [T-1:0] m_mask;
  int           m_pcs [T];
  bit           m_ret [T];
  bit           m_en  [T];

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [T*A-1:0] mk(input int a0, input int a1, input int a2, input int a3);
    logic [T*A-1:0] v;
    v = '0;
    v[0*A +: A] = A'(a0);
    v[1*A +: A] = A'(a1);
    v[2*A +: A] = A'(a2);
    v[3*A +: A] = A'(a3);
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_cur = '0;
    m_mask = '0;
    for (int i = 0; i < T; i++) begin
      m_pcs[i] = 0;
      m_ret[i] = 1'b1;
      m_en[i]  = 1'b0;
    end
  endtask

  task automatic model_update();
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
    int best;
    bool_all: begin
      best = 1 << 30;
      for (int i = 0; i < T; i++) begin
        if (m_mask[i]) begin
          if (bus.decoded_ret) m_ret[i] = 1'b1;
          else m_pcs[i] = int'(bus.next_pc[A*i +: A]);
        end
      end
      for (int i = 0; i < T; i++) begin
        if (!m_ret[i] && m_pcs[i] < best) best = m_pcs[i];
      end
      if (best == (1 << 30)) begin
        m_mask = '0;
        m_st = 7;
      end else begin
        m_cur = A'(best);
        for (int i = 0; i < T; i++) m_mask[i] = !m_ret[i] && (m_pcs[i] == best);
        m_st = 1;
      end
    end
`else
    if (bus.decoded_ret) begin
      for (int i = 0; i < T; i++) m_ret[i] = 1'b1;
      m_mask = '0;
      m_st = 7;
    end else begin
      for (int i = T - 1; i >= 0; i--) begin
        if (m_mask[i]) begin
          m_cur = bus.next_pc[A*i +: A];
          break;
        end
      end
      for (int i = 0; i < T; i++) m_mask[i] = m_en[i] && !m_ret[i];
      m_st = 1;
    end
`endif
  endtask

  task automatic model_step();
    int n;
    bit busy;
    case (m_st)
      0: begin
        if (bus.start) begin
          n = int'(bus.thread_count);
          if (n > T) n = T;
          m_cur = '0;
          for (int i = 0; i < T; i++) begin
            m_en[i]   = (i < n);
            m_ret[i]  = !(i < n);
            m_pcs[i]  = 0;
            m_mask[i] = (i < n);
          end
          m_st = (n == 0) ? 7 : 1;
        end
      end
      1: if (bus.fetcher_state == 3'b010) m_st = 2;
      2: m_st = 3;
      3: m_st = 4;
      4: begin
        busy = 1'b0;
        for (int i = 0; i < T; i++) begin
          if (m_mask[i] && (bus.lsu_state[2*i +: 2] == 2'd1 || bus.lsu_state[2*i +: 2] == 2'd2))
            busy = 1'b1;
        end
        if (!busy) m_st = 5;
      end
      5: m_st = 6;
      6: model_update();
      7: if (!bus.start) m_st = 0;
      default: m_st = 0;
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_state", 32'(bus.core_state), 32'(m_st));
      chk("model_pc", 32'(bus.current_pc), 32'(m_cur));
      chk("model_mask", 32'(bus.active_mask), 32'(m_mask));
      chk("model_done", 32'(bus.done), 32'(m_st == 7));
    end
  end

  task automatic start_block(input int tc);
    logic [31:0] t;
    t = tc;
    bus.thread_count = t[CW-1:0];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_state(input int s, input string nm);
    int g;
    g = 0;
    while (int'(bus.core_state) != s && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk(nm, 32'(bus.core_state), 32'(s));
  endtask

  task automatic run_instr(input logic [T*A-1:0] npc, input logic ret,
                           input logic [2*T-1:0] lsu_during, input logic [2*T-1:0] lsu_after,
                           input int wait_cyc, output int waits);
    int g;
    waits = 0;
    g = 0;
    bus.next_pc = npc;
    bus.decoded_ret = ret;
    bus.lsu_state = (wait_cyc > 0) ? lsu_during : lsu_after;
    bus.fetcher_state = 3'b010;
    while (bus.core_state != 3'd6 && g < 100) begin
      @(negedge clk);
      g++;
      if (bus.core_state != 3'd1) bus.fetcher_state = 3'b000;
      if (bus.core_state == 3'd4) begin
        waits++;
        if (waits >= wait_cyc) bus.lsu_state = lsu_after;
      end
    end
    chk("instr_reach_update", 32'(bus.core_state), 32'd6);
    @(negedge clk);
    bus.decoded_ret = 1'b0;
    bus.lsu_state = '0;
    bus.fetcher_state = 3'b000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ws;
    int exp_seq [8];
    logic [31:0] r;
    logic [T*A-1:0] npc;

    exp_seq = '{1, 1, 2, 3, 4, 5, 6, 1};
    bus.start = 1'b0;
    bus.thread_count = '0;
    bus.fetcher_state = 3'b000;
    bus.decoded_mem_read_enable = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    bus.decoded_ret = 1'b0;
    bus.lsu_state = '0;
    bus.next_pc = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(bus.core_state), 32'd0);
    chk("rst_pc", 32'(bus.current_pc), 32'd0);
    chk("rst_mask", 32'(bus.active_mask), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    #2 reset_n = 1'b1;
    cmp_en = 1'b1;

    // Basic full-width instruction walk through every pipeline state
    @(negedge clk);
    bus.next_pc = mk(1, 1, 1, 1);
    bus.thread_count = CW'(4);
    bus.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("seq_state", 32'(bus.core_state), 32'(exp_seq[k]));
      bus.start = 1'b0;
      bus.fetcher_state = (k == 1) ? 3'b010 : 3'b000;
    end
    chk("seq_pc", 32'(bus.current_pc), 32'd1);
    chk("seq_mask", 32'(bus.active_mask), 32'hF);
    run_instr(mk(0, 0, 0, 0), 1'b1, '0, '0, 0, ws);
    chk("ret_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("ret_idle", 32'(bus.core_state), 32'd0);

    // Three lanes, lane 1 stalls WAIT, lane 3 is outside the mask
    start_block(3);
    chk("tc3_mask", 32'(bus.active_mask), 32'h7);
    run_instr(mk(2, 2, 2, 2), 1'b0, 8'b1000_1000, 8'b1000_0000, 5, ws);
    chk("wait_cycles", 32'(ws), 32'd5);
    chk("tc3_mask_after", 32'(bus.active_mask), 32'h7);
    chk("tc3_pc_after", 32'(bus.current_pc), 32'd2);
    run_instr(mk(0, 0, 0, 0), 1'b1, '0, '0, 0, ws);
    @(negedge clk);
    chk("tc3_idle", 32'(bus.core_state), 32'd0);

    // Divergence and reconvergence
    start_block(4);
    run_instr(mk(4, 4, 4, 4), 1'b0, '0, '0, 0, ws);
    chk("div_pc4", 32'(bus.current_pc), 32'd4);
    chk("div_mask4", 32'(bus.active_mask), 32'hF);
    run_instr(mk(9, 5, 9, 5), 1'b0, '0, '0, 0, ws);
    chk("div_pc5", 32'(bus.current_pc), 32'd5);
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
    chk("div_mask5", 32'(bus.active_mask), 32'hA);
`else
    chk("div_mask5", 32'(bus.active_mask), 32'hF);
`endif
    run_instr(mk(0, 9, 0, 9), 1'b0, '0, '0, 0, ws);
    chk("conv_pc9", 32'(bus.current_pc), 32'd9);
    chk("conv_mask9", 32'(bus.active_mask), 32'hF);
`ifdef SIMT_SCHEDULER_DIVERGENCE_EN
    run_instr(mk(9, 5, 9, 5), 1'b0, '0, '0, 0, ws);
    chk("div2_mask", 32'(bus.active_mask), 32'hA);
    run_instr(mk(0, 0, 0, 0), 1'b1, '0, '0, 0, ws);
    chk("retdiv_pc", 32'(bus.current_pc), 32'd9);
    chk("retdiv_mask", 32'(bus.active_mask), 32'h5);
`endif
    run_instr(mk(0, 0, 0, 0), 1'b1, '0, '0, 0, ws);
    chk("final_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    chk("done_hold", 32'(bus.core_state), 32'd7);
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_release", 32'(bus.core_state), 32'd0);

    // Zero and oversized thread counts
    start_block(0);
    chk("tc0_state", 32'(bus.core_state), 32'd7);
    chk("tc0_done", 32'(bus.done), 32'd1);
    chk("tc0_mask", 32'(bus.active_mask), 32'd0);
    @(negedge clk);
    chk("tc0_idle", 32'(bus.core_state), 32'd0);
    start_block(7);
    chk("tc7_mask", 32'(bus.active_mask), 32'hF);
    run_instr(mk(0, 0, 0, 0), 1'b1, '0, '0, 0, ws);
    @(negedge clk);
    chk("tc7_idle", 32'(bus.core_state), 32'd0);

    // Asynchronous reset in the middle of WAIT
    start_block(4);
    run_instr(mk(3, 3, 3, 3), 1'b0, '0, '0, 0, ws);
    bus.fetcher_state = 3'b010;
    bus.lsu_state = 8'b0000_0001;
    wait_state(4, "reach_wait");
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.core_state), 32'd0);
    chk("arst_pc", 32'(bus.current_pc), 32'd0);
    chk("arst_mask", 32'(bus.active_mask), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    bus.fetcher_state = 3'b000;
    bus.lsu_state = '0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    start_block(2);
    chk("restart_state", 32'(bus.core_state), 32'd1);
    chk("restart_pc", 32'(bus.current_pc), 32'd0);
    chk("restart_mask", 32'(bus.active_mask), 32'h3);
    run_instr(mk(0, 0, 0, 0), 1'b1, '0, '0, 0, ws);
    @(negedge clk);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start = ($urandom % 3) != 0;
      r = $urandom;
      bus.thread_count = r[CW-1:0];
      r = $urandom;
      bus.fetcher_state = (($urandom % 3) == 0) ? 3'b010 : r[2:0];
      r = $urandom;
      bus.lsu_state = (($urandom % 2) == 0) ? r[2*T-1:0] : '0;
      for (int i = 0; i < T; i++) npc[A*i +: A] = A'($urandom_range(0, 6));
      bus.next_pc = npc;
      bus.decoded_ret = (($urandom % 5) == 0);
      bus.decoded_mem_read_enable = 1'($urandom % 2);
      bus.decoded_mem_write_enable = 1'($urandom % 2);
      if (($urandom % 400) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/simt_scheduler.md
SIMT_SCHEDULER -- requirements
Module: simt_scheduler

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4: thread lanes scheduled (T), power of two ≥ 2.
REQ-002 Parameter PROGRAM_MEM_ADDR_BITS, default 8: PC width (A).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level request to begin kernel block execution.
REQ-006 thread_count  in  $clog2(T)+1  lanes enabled for this block, sampled in IDLE on start.
REQ-007 fetcher_state  in  3  fetcher status; 3'b010 = FETCHED.
REQ-008 decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret  in  1 each  decoded control.
REQ-009 lsu_state  in  2*T  per-lane LSU state, lane i at [2i+1:2i]; 01 REQUESTING, 10 WAITING.
REQ-010 next_pc  in  A*T  per-lane next PC, lane i at [A*i+A-1:A*i].
REQ-011 core_state  out  3  IDLE 0, FETCH 1, DECODE 2, REQUEST 3, WAIT 4, EXECUTE 5, UPDATE 6, DONE 7.
REQ-012 current_pc  out  A  PC of instruction being issued.
REQ-013 active_mask  out  T  lanes executing the current instruction.
REQ-014 done  out  1  high exactly while core_state == DONE.

Function
REQ-015 IDLE: on start=1, latch n = min(thread_count, T); enabled = lanes 0..n-1; per-lane pc = 0; retired = ~enabled; go FETCH, or DONE if n == 0.
REQ-016 FETCH → DECODE on the cycle fetcher_state == 3'b010; otherwise hold.
REQ-017 DECODE → REQUEST, REQUEST → WAIT, EXECUTE → UPDATE unconditionally, one cycle each.
REQ-018 WAIT → EXECUTE on the first cycle in which no lane in active_mask has lsu_state 01 or 10; lanes outside active_mask are ignored.
REQ-019 UPDATE, decoded_ret=1: active lanes are marked retired; if all lanes retired go DONE, else reselect (REQ-021) and go FETCH.
REQ-020 UPDATE, decoded_ret=0: each active lane's stored pc ← its next_pc slice; then reselect and go FETCH.
REQ-021 Reselect (min-PC reconvergence): current_pc ← minimum stored pc over non-retired lanes; active_mask ← non-retired lanes whose stored pc equals that minimum; comparison unsigned, A bits, no wrap handling beyond natural A-bit arithmetic.
REQ-022 Divergence: lanes with larger pc stay parked (pc held, not in mask) until current_pc reaches their pc, where they rejoin automatically.
REQ-023 DONE: done=1; hold while start=1; start=0 → IDLE next cycle.
REQ-024 start is ignored in all states other than IDLE and DONE; thread_count is ignored outside IDLE.
REQ-025 active_mask is constant from FETCH through UPDATE of one instruction; changes only at the UPDATE → FETCH edge.

Reset
REQ-026 reset_n=0 asynchronously forces core_state=IDLE, current_pc=0, active_mask=0, done=0, all stored pcs=0, retired=all ones, enabled=0.
REQ-027 Reset asserted mid-instruction aborts immediately; no retirement or pc update is committed.
REQ-028 Release is synchronous to clk; first possible FETCH is the cycle after start is seen in IDLE.

Configuration
REQ-029 Macro SIMT_SCHEDULER_DIVERGENCE_EN defined: behaviour as REQ-020..REQ-022.
REQ-030 Macro undefined: no per-lane pc storage; in UPDATE current_pc ← next_pc of the highest-indexed active lane; active_mask = all enabled, non-retired lanes; decoded_ret retires all lanes and goes DONE.

Verification
REQ-031 T=4, thread_count=4, start, fetcher FETCHED after 2 cycles, LSU idle, next_pc all 1 → sequence 1,2,3,4,5,6,1; current_pc=1, active_mask=4'b1111.
REQ-032 thread_count=3, LSU lane 1 WAITING for 5 cycles in WAIT → WAIT held 5 cycles; lane 3 lsu_state=10 has no effect; active_mask=4'b0111.
REQ-033 (DIVERGENCE_EN) pc=4, next_pc lanes {9,5,9,5} → current_pc=5, mask=4'b1010; next UPDATE next_pc=9 for lanes 1,3 → current_pc=9, mask=4'b1111.
REQ-034 Divergent lanes 1,3 at pc 5 with decoded_ret=1 → lanes 1,3 retired, current_pc=9, mask=4'b0101; subsequent ret → DONE, done=1; start=0 → IDLE.
REQ-035 thread_count=0 with start → DONE next cycle, done=1, active_mask=0.
REQ-036 reset_n pulsed low during WAIT → outputs at reset values same cycle, core_state=IDLE; new start restarts from pc 0.
